vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 85 ++++++++
 tb/tb_vga_timing_gen.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with registered sync, blank and pulse outputs.
// Optional frame counter enabled by defining macro VGA_FRAME_CNT_EN; otherwise frame_cnt is tied to 0.
module vga_timing_gen #(
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_DISP_END = 10'(H_DISPLAY);
    localparam logic [9:0] V_DISP_END = 10'(V_DISPLAY);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] H_SYNC_END = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] V_SYNC_END = 10'(V_DISPLAY + V_FRONT + V_SYNC);

    logic       h_wrap;
    logic       v_wrap;
    logic [9:0] hpos_next;
    logic [9:0] vpos_next;

    always_comb begin
        h_wrap    = (hpos == H_LAST);
        v_wrap    = (vpos == V_LAST);
        hpos_next = h_wrap ? '0 : hpos + 10'd1;
        vpos_next = vpos;
        if (h_wrap) begin
            vpos_next = v_wrap ? '0 : vpos + 10'd1;
        end
    end

    // Decode from the next position so every registered output lines up with the hpos/vpos it is shown with.
    always_ff @(posedge clk) begin
        if (reset) begin
            hpos        <= '0;
            vpos        <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            display_on  <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hpos        <= hpos_next;
            vpos        <= vpos_next;
            hsync       <= !((hpos_next >= H_SYNC_BEG) && (hpos_next < H_SYNC_END));
            vsync       <= !((vpos_next >= V_SYNC_BEG) && (vpos_next < V_SYNC_END));
            display_on  <= (hpos_next < H_DISP_END) && (vpos_next < V_DISP_END);
            line_start  <= h_wrap;
            frame_start <= h_wrap && v_wrap;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (h_wrap && v_wrap) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end
`else
    assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a reduced raster (17x11) so whole frames and 256-frame counter wrap stay short.
// Expectations for frame_cnt follow whether VGA_FRAME_CNT_EN is defined for this build.
module tb_vga_timing_gen;

    localparam int HD = 10, HF = 2, HS = 3, HB = 2;
    localparam int VD = 6,  VF = 1, VS = 2, VB = 2;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
`ifdef VGA_FRAME_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       de;
        logic       ls;
        logic       fs;
        logic [7:0] fc;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       hsync, vsync, display_on, line_start, frame_start;
    logic [9:0] hpos, vpos;
    logic [7:0] frame_cnt;

    vga_timing_gen #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .hsync(hsync),
        .vsync(vsync),
        .display_on(display_on),
        .hpos(hpos),
        .vpos(vpos),
        .line_start(line_start),
        .frame_start(frame_start),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    obs_t       sb[$];
    int         checks = 0;
    int         failures = 0;
    int         mh = 0;
    int         mv = 0;
    logic [7:0] mfc = '0;

    function automatic obs_t observe();
        obs_t o;
        o.h  = hpos;
        o.v  = vpos;
        o.hs = hsync;
        o.vs = vsync;
        o.de = display_on;
        o.ls = line_start;
        o.fs = frame_start;
        o.fc = frame_cnt;
        return o;
    endfunction

    function automatic string show(input obs_t o);
        return $sformatf("h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d",
                         o.h, o.v, o.hs, o.vs, o.de, o.ls, o.fs, o.fc);
    endfunction

    // Drive one clock with the given reset level, advance the raster model and queue its expectation.
    task automatic drive_cycle(input logic rst);
        obs_t e;
        reset = rst;
        @(posedge clk);
        e.ls = 1'b0;
        e.fs = 1'b0;
        if (rst) begin
            mh  = 0;
            mv  = 0;
            mfc = '0;
        end else if (mh == HT - 1) begin
            e.ls = 1'b1;
            mh   = 0;
            if (mv == VT - 1) begin
                mv   = 0;
                e.fs = 1'b1;
                if (CNT_EN) mfc = mfc + 8'd1;
            end else begin
                mv = mv + 1;
            end
        end else begin
            mh = mh + 1;
        end
        e.h  = 10'(mh);
        e.v  = 10'(mv);
        e.hs = !(mh >= HD + HF && mh < HD + HF + HS);
        e.vs = !(mv >= VD + VF && mv < VD + VF + VS);
        e.de = (mh < HD) && (mv < VD);
        e.fc = mfc;
        sb.push_back(e);
        #1;
    endtask

    task automatic test_reset();
        obs_t e, got;
        drive_cycle(1'b1);
        e = sb.pop_front(); got = observe(); checks++;
        if (got !== e) begin failures++; $display("FAIL reset_init got %s want %s", show(got), show(e)); end
        for (int n = 0; n < HT * VT && !(mh == 8 && mv == 4); n++) begin
            drive_cycle(1'b0);
            e = sb.pop_front(); got = observe(); checks++;
            if (got !== e) begin failures++; $display("FAIL reset_run got %s want %s", show(got), show(e)); end
        end
        checks++;
        if (hpos !== 10'd8 || vpos !== 10'd4) begin
            failures++; $display("FAIL reset_reach got (%0d,%0d) want (8,4)", hpos, vpos);
        end
        for (int n = 0; n < 3; n++) begin
            drive_cycle(1'b1);
            e = sb.pop_front(); got = observe(); checks++;
            if (got !== e) begin failures++; $display("FAIL reset_hold got %s want %s", show(got), show(e)); end
            checks++;
            if ({hpos, vpos, hsync, vsync, display_on, line_start, frame_start, frame_cnt} !== {10'd0, 10'd0, 5'b11100, 8'd0}) begin
                failures++; $display("FAIL reset_values got %s want h=0 v=0 hs=1 vs=1 de=1 ls=0 fs=0 fc=0", show(got));
            end
        end
        drive_cycle(1'b0);
        e = sb.pop_front(); got = observe(); checks++;
        if (got !== e) begin failures++; $display("FAIL reset_release got %s want %s", show(got), show(e)); end
        checks++;
        if (hpos !== 10'd1) begin failures++; $display("FAIL reset_first_step got hpos=%0d want 1", hpos); end
    endtask

    task automatic test_horizontal();
        obs_t e, got;
        int   period = 0, de_cnt = 0, hs_cnt = 0, hs_first = -1;
        for (int n = 0; n < 2 * HT && line_start !== 1'b1; n++) begin
            drive_cycle(1'b0);
            e = sb.pop_front(); got = observe(); checks++;
            if (got !== e) begin failures++; $display("FAIL horiz_seek got %s want %s", show(got), show(e)); end
        end
        checks++;
        if (line_start !== 1'b1) begin failures++; $display("FAIL horiz_timeout got ls=%b want 1", line_start); end
        do begin
            if (display_on === 1'b1) de_cnt++;
            if (hsync === 1'b0) begin
                if (hs_first < 0) hs_first = int'(hpos);
                hs_cnt++;
            end
            drive_cycle(1'b0);
            period++;
            e = sb.pop_front(); got = observe(); checks++;
            if (got !== e) begin failures++; $display("FAIL horiz_line got %s want %s", show(got), show(e)); end
        end while (line_start !== 1'b1 && period < 2 * HT);
        checks++;
        if (period != HT) begin failures++; $display("FAIL horiz_period got %0d want %0d", period, HT); end
        checks++;
        if (de_cnt != HD) begin failures++; $display("FAIL horiz_display got %0d want %0d", de_cnt, HD); end
        checks++;
        if (hs_cnt != HS || hs_first != HD + HF) begin
            failures++; $display("FAIL horiz_hsync got len=%0d start=%0d want len=%0d start=%0d", hs_cnt, hs_first, HS, HD + HF);
        end
    endtask

    task automatic test_vertical();
        obs_t e, got;
        int   period = 0, de_cnt = 0, vs_cnt = 0, vs_first = -1, de_late = 0;
        for (int n = 0; n < 2 * HT * VT && frame_start !== 1'b1; n++) begin
            drive_cycle(1'b0);
            e = sb.pop_front(); got = observe(); checks++;
            if (got !== e) begin failures++; $display("FAIL vert_seek got %s want %s", show(got), show(e)); end
        end
        checks++;
        if (frame_start !== 1'b1) begin failures++; $display("FAIL vert_timeout got fs=%b want 1", frame_start); end
        do begin
            if (display_on === 1'b1) begin
                de_cnt++;
                if (vpos >= 10'(VD)) de_late++;
            end
            if (vsync === 1'b0) begin
                if (vs_first < 0) vs_first = int'(vpos);
                vs_cnt++;
            end
            drive_cycle(1'b0);
            period++;
            e = sb.pop_front(); got = observe(); checks++;
            if (got !== e) begin failures++; $display("FAIL vert_frame got %s want %s", show(got), show(e)); end
        end while (frame_start !== 1'b1 && period < 2 * HT * VT);
        checks++;
        if (period != HT * VT) begin failures++; $display("FAIL vert_period got %0d want %0d", period, HT * VT); end
        checks++;
        if (vs_cnt != VS * HT || vs_first != VD + VF) begin
            failures++; $display("FAIL vert_vsync got len=%0d start=%0d want len=%0d start=%0d", vs_cnt, vs_first, VS * HT, VD + VF);
        end
        checks++;
        if (de_cnt != HD * VD || de_late != 0) begin
            failures++; $display("FAIL vert_display got %0d (late %0d) want %0d (late 0)", de_cnt, de_late, HD * VD);
        end
    endtask

    task automatic test_wrap();
        obs_t       e, got;
        logic [7:0] want_fc;
        for (int n = 0; n < 2 * HT * VT && !(mh == HT - 1 && mv == VT - 1); n++) begin
            drive_cycle(1'b0);
            e = sb.pop_front(); got = observe(); checks++;
            if (got !== e) begin failures++; $display("FAIL wrap_seek got %s want %s", show(got), show(e)); end
        end
        checks++;
        if (hpos !== 10'(HT - 1) || vpos !== 10'(VT - 1)) begin
            failures++; $display("FAIL wrap_reach got (%0d,%0d) want (%0d,%0d)", hpos, vpos, HT - 1, VT - 1);
        end
        want_fc = CNT_EN ? mfc + 8'd1 : 8'd0;
        drive_cycle(1'b0);
        e = sb.pop_front(); got = observe(); checks++;
        if (got !== e) begin failures++; $display("FAIL wrap_step got %s want %s", show(got), show(e)); end
        checks++;
        if (hpos !== 10'd0 || vpos !== 10'd0 || line_start !== 1'b1 || frame_start !== 1'b1 || frame_cnt !== want_fc) begin
            failures++; $display("FAIL wrap_values got %s want h=0 v=0 ls=1 fs=1 fc=%0d", show(got), want_fc);
        end
    endtask

    task automatic test_mid_reset();
        obs_t e, got;
        drive_cycle(1'b1);
        e = sb.pop_front(); got = observe(); checks++;
        if (got !== e) begin failures++; $display("FAIL mid_init got %s want %s", show(got), show(e)); end
        for (int n = 0; n < HT * VT && !(mh == 12 && mv == 5); n++) begin
            drive_cycle(1'b0);
            e = sb.pop_front(); got = observe(); checks++;
            if (got !== e) begin failures++; $display("FAIL mid_run got %s want %s", show(got), show(e)); end
        end
        drive_cycle(1'b1);
        e = sb.pop_front(); got = observe(); checks++;
        if (got !== e) begin failures++; $display("FAIL mid_reset got %s want %s", show(got), show(e)); end
        checks++;
        if (hpos !== 10'd0 || vpos !== 10'd0 || frame_start !== 1'b0 || frame_cnt !== 8'd0) begin
            failures++; $display("FAIL mid_values got %s want h=0 v=0 fs=0 fc=0", show(got));
        end
    endtask

    task automatic test_counter();
        obs_t e, got;
        int   wait_cnt;
        drive_cycle(1'b1);
        e = sb.pop_front(); got = observe(); checks++;
        if (got !== e) begin failures++; $display("FAIL cnt_init got %s want %s", show(got), show(e)); end
        for (int k = 1; k <= 256; k++) begin
            wait_cnt = 0;
            do begin
                drive_cycle(1'b0);
                wait_cnt++;
                e = sb.pop_front(); got = observe(); checks++;
                if (got !== e) begin failures++; $display("FAIL cnt_run got %s want %s", show(got), show(e)); end
            end while (frame_start !== 1'b1 && wait_cnt <= HT * VT);
            checks++;
            if (wait_cnt != HT * VT) begin
                failures++; $display("FAIL cnt_period frame %0d got %0d want %0d", k, wait_cnt, HT * VT);
            end
            checks++;
            if (frame_cnt !== (CNT_EN ? 8'(k) : 8'd0)) begin
                failures++; $display("FAIL cnt_value frame %0d got %0d want %0d", k, frame_cnt, CNT_EN ? 8'(k) : 8'd0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_horizontal();
        test_vertical();
        test_wrap();
        test_mid_reset();
        test_counter();
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL sb_drain got %0d left want 0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
